// File: rtl/mac_tx_scheduler.sv
// Round-robin scheduler sharing one UDP transmit path among NUM_CH video FIFOs (2-byte tag + PKT_LEN payload bytes).
// Latency: ARB 1 cycle, tag 2 cycles, each payload byte written 1 cycle after its FIFO read, then a 1-cycle udp_tx_req.
// Backpressure: almost_full stalls new FIFO reads (the in-flight byte is still written); ctrl_busy/sched_en gate starts in IDLE.
module mac_tx_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int PKT_LEN = 1024,
    parameter int GAP_CYC = 64,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sched_en,
    input  logic                  ctrl_busy,
    input  logic [NUM_CH-1:0]     ch_ready,
    input  logic [8*NUM_CH-1:0]   ch_data,
    output logic [NUM_CH-1:0]     ch_rd_en,
    output logic [NUM_CH-1:0]     ch_grant,
    output logic [7:0]            ram_wr_data,
    output logic                  ram_wr_en,
    input  logic                  almost_full,
    output logic                  udp_tx_req,
    output logic [15:0]           udp_send_data_length,
    input  logic                  udp_tx_end,
    output logic                  sched_busy,
    output logic                  tx_timeout
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RW = $clog2(PKT_LEN + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_HDR0, S_HDR1, S_PAYLOAD, S_REQ, S_WAIT_END, S_GAP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   last;
    logic [CW-1:0]   grant_idx;
    logic            grant_vld;
    logic            arb_found;
    logic [CW-1:0]   arb_idx;
    int              cand;
    logic [7:0]      seq [NUM_CH];
    logic [RW-1:0]   rd_cnt;
    logic            rd_pend;
    logic            rd_issue;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   gap_cnt;
    logic            timeout_hit;
    logic            gap_done;

    // A read is issued while payload reads remain and the UDP buffer has room.
    assign rd_issue    = (state == S_PAYLOAD) && !almost_full && (rd_cnt < RW'(PKT_LEN));
    // Timer value TIMEOUT-1 is the last cycle of the wait window; an end pulse in that cycle still wins.
    assign timeout_hit = (state == S_WAIT_END) && !udp_tx_end && (timer == TW'(TIMEOUT - 1));
    assign gap_done    = (gap_cnt == GW'(GAP_CYC - 1));
    assign sched_busy  = (state != S_IDLE);

    // Round-robin search starting just after the last granted channel; lowest offset wins.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = int'(last) + k;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            if (ch_ready[CW'(cand)]) begin
                arb_found = 1'b1;
                arb_idx   = CW'(cand);
            end
        end
    end

    // One-hot decode of the owning channel and of the FIFO read strobe.
    always_comb begin
        ch_grant = '0;
        ch_rd_en = '0;
        if (grant_vld) ch_grant[grant_idx] = 1'b1;
        if (rd_issue)  ch_rd_en[grant_idx] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and buffer-write / request outputs.
    always_comb begin
        state_nxt   = state;
        ram_wr_en   = 1'b0;
        ram_wr_data = 8'd0;
        udp_tx_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sched_en && !ctrl_busy && (|ch_ready)) state_nxt = S_ARB;
            end
            S_ARB: begin
                state_nxt = arb_found ? S_HDR0 : S_IDLE;
            end
            S_HDR0: begin
                ram_wr_en   = 1'b1;
                ram_wr_data = 8'(grant_idx);
                state_nxt   = S_HDR1;
            end
            S_HDR1: begin
                ram_wr_en   = 1'b1;
                ram_wr_data = seq[grant_idx];
                state_nxt   = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                // FIFO data arrives one cycle after the read, so the write trails the strobe.
                if (rd_pend) begin
                    ram_wr_en   = 1'b1;
                    ram_wr_data = ch_data[{grant_idx, 3'b000} +: 8];
                    if (rd_cnt == RW'(PKT_LEN)) state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                udp_tx_req = 1'b1;
                state_nxt  = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (udp_tx_end || timeout_hit) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, counters, sequence numbers, length and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last                 <= CW'(NUM_CH - 1);
            grant_idx            <= '0;
            grant_vld            <= 1'b0;
            rd_cnt               <= '0;
            rd_pend              <= 1'b0;
            timer                <= '0;
            gap_cnt              <= '0;
            udp_send_data_length <= 16'd0;
            tx_timeout           <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) seq[i] <= 8'd0;
        end else begin
            rd_pend <= rd_issue;
            case (state)
                S_ARB: begin
                    if (arb_found) begin
                        grant_idx            <= arb_idx;
                        last                 <= arb_idx;
                        grant_vld            <= 1'b1;
                        udp_send_data_length <= 16'(PKT_LEN + 2);
                    end
                end
                S_HDR0: rd_cnt <= '0;
                S_PAYLOAD: begin
                    if (rd_issue) rd_cnt <= rd_cnt + RW'(1);
                end
                S_REQ: begin
                    seq[grant_idx] <= seq[grant_idx] + 8'd1;
                    timer          <= '0;
                end
                S_WAIT_END: begin
                    timer   <= timer + TW'(1);
                    gap_cnt <= '0;
                    if (timeout_hit) tx_timeout <= 1'b1;
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                    if (gap_done) begin
                        grant_vld            <= 1'b0;
                        udp_send_data_length <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// Scoreboard bench for mac_tx_scheduler: expected bytes and requests are queued at stimulus time.
// A negedge monitor pops and compares every buffer write and every udp_tx_req.
// A FIFO model supplies ch_data with one-cycle read latency; a responder returns udp_tx_end.
module tb_mac_tx_scheduler;

    localparam int NUM_CH  = 4;
    localparam int PKT_LEN = 8;
    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 20;

    logic                 clk;
    logic                 rst;
    logic                 sched_en;
    logic                 ctrl_busy;
    logic [NUM_CH-1:0]    ch_ready;
    logic [8*NUM_CH-1:0]  ch_data;
    logic [NUM_CH-1:0]    ch_rd_en;
    logic [NUM_CH-1:0]    ch_grant;
    logic [7:0]           ram_wr_data;
    logic                 ram_wr_en;
    logic                 almost_full;
    logic                 udp_tx_req;
    logic [15:0]          udp_send_data_length;
    logic                 udp_tx_end;
    logic                 sched_busy;
    logic                 tx_timeout;

    typedef struct packed {
        logic [NUM_CH-1:0] grant;
        logic [15:0]       len;
    } req_t;

    logic [7:0] exp_wr [$];
    req_t       exp_req [$];

    int checks = 0;
    int errors = 0;
    int n_req  = 0;
    int pkt_wr = 0;
    int fifo_ptr [NUM_CH];
    int m_ptr [NUM_CH];
    int m_seq [NUM_CH];
    int m_last;
    logic rsp_en;
    int   rsp_delay;
    logic [7:0] mon_b;
    req_t       mon_r;

    mac_tx_scheduler #(
        .NUM_CH(NUM_CH), .PKT_LEN(PKT_LEN), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en), .ctrl_busy(ctrl_busy),
        .ch_ready(ch_ready), .ch_data(ch_data), .ch_rd_en(ch_rd_en), .ch_grant(ch_grant),
        .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en), .almost_full(almost_full),
        .udp_tx_req(udp_tx_req), .udp_send_data_length(udp_send_data_length),
        .udp_tx_end(udp_tx_end), .sched_busy(sched_busy), .tx_timeout(tx_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] fifo_byte(input int ch, input int p);
        return 8'(32'hD0 + ch * 32'h20 + p);
    endfunction

    // Video FIFO model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_rd_en[i]) begin
                ch_data[8*i +: 8] <= fifo_byte(i, fifo_ptr[i]);
                fifo_ptr[i]       <= fifo_ptr[i] + 1;
            end
        end
    end

    // Monitor: every write and request is checked against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            pkt_wr = 0;
        end else begin
            if (ram_wr_en) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    mon_b = exp_wr.pop_front();
                    chk("wr_byte", 32'(ram_wr_data), 32'(mon_b));
                end
                pkt_wr++;
            end
            if (udp_tx_req) begin
                n_req++;
                chk("req_expected", 32'(exp_req.size() > 0), 32'd1);
                if (exp_req.size() > 0) begin
                    mon_r = exp_req.pop_front();
                    chk("req_grant", 32'(ch_grant), 32'(mon_r.grant));
                    chk("req_len", 32'(udp_send_data_length), 32'(mon_r.len));
                end
                chk("req_nwr", pkt_wr, PKT_LEN + 2);
                pkt_wr = 0;
            end
        end
    end

    // UDP responder: pulse udp_tx_end rsp_delay cycles after each request.
    initial begin
        udp_tx_end = 1'b0;
        forever begin
            @(negedge clk);
            if (udp_tx_req && rsp_en) begin
                repeat (rsp_delay) @(negedge clk);
                #1 udp_tx_end = 1'b1;
                @(negedge clk);
                #1 udp_tx_end = 1'b0;
            end
        end
    end

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NUM_CH; i++) begin
            m_seq[i] = 0;
            m_ptr[i] = fifo_ptr[i];
        end
        m_last = NUM_CH - 1;
    endtask

    function automatic int model_arb(input logic [NUM_CH-1:0] rdy);
        for (int k = 1; k <= NUM_CH; k++) begin
            if (rdy[(m_last + k) % NUM_CH]) return (m_last + k) % NUM_CH;
        end
        return 0;
    endfunction

    task automatic push_pkt(input int ch);
        req_t r;
        exp_wr.push_back(8'(ch));
        exp_wr.push_back(8'(m_seq[ch]));
        for (int k = 0; k < PKT_LEN; k++) exp_wr.push_back(fifo_byte(ch, m_ptr[ch] + k));
        m_ptr[ch] = m_ptr[ch] + PKT_LEN;
        r.grant = '0;
        r.grant[ch] = 1'b1;
        r.len = 16'(PKT_LEN + 2);
        exp_req.push_back(r);
        m_seq[ch] = (m_seq[ch] + 1) % 256;
        m_last = ch;
    endtask

    task automatic push_n(input logic [NUM_CH-1:0] rdy, input int n);
        for (int i = 0; i < n; i++) push_pkt(model_arb(rdy));
    endtask

    task automatic wait_req(input int target);
        for (int i = 0; i < 2000 && n_req < target; i++) step;
        chk("wait_req", n_req, target);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 500 && sched_busy; i++) step;
        chk("wait_idle", 32'(sched_busy), 0);
    endtask

    task automatic wait_pkt_wr(input int target);
        for (int i = 0; i < 200 && pkt_wr != target; i++) step;
        chk("wait_pkt_wr", pkt_wr, target);
    endtask

    task automatic run_pkts(input logic [NUM_CH-1:0] rdy, input int n);
        int base;
        base = n_req;
        push_n(rdy, n);
        ch_ready = rdy;
        wait_req(base + n);
        ch_ready = '0;
        wait_idle;
    endtask

    task automatic chk_quiet(input string p);
        chk({p, "_rd_en"}, 32'(ch_rd_en), 0);
        chk({p, "_grant"}, 32'(ch_grant), 0);
        chk({p, "_wr_en"}, 32'(ram_wr_en), 0);
        chk({p, "_wr_data"}, 32'(ram_wr_data), 0);
        chk({p, "_tx_req"}, 32'(udp_tx_req), 0);
        chk({p, "_busy"}, 32'(sched_busy), 0);
        chk({p, "_timeout"}, 32'(tx_timeout), 0);
        chk({p, "_len"}, 32'(udp_send_data_length), 0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
        model_reset;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed scenarios.
    initial begin
        int base;
        int n;
        int nw;
        rst = 1'b1; sched_en = 1'b0; ctrl_busy = 1'b0; ch_ready = '0;
        almost_full = 1'b0; rsp_en = 1'b1; rsp_delay = 10;
        repeat (3) step;
        chk_quiet("reset");
        rst = 1'b0;
        model_reset;
        sched_en = 1'b1;

        // Single channel, two packets: tags 00,00 then 00,01.
        run_pkts(4'b0001, 2);

        // Round robin from reset: 0,1,2,3,0 with independent sequence numbers.
        do_reset;
        run_pkts(4'b1111, 5);

        // Back-pressure mid-payload for five cycles.
        base = n_req;
        push_n(4'b0100, 1);
        ch_ready = 4'b0100;
        wait_pkt_wr(4);
        almost_full = 1'b1;
        nw = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rd_en", 32'(ch_rd_en), 0);
            nw += int'(ram_wr_en);
            step;
        end
        almost_full = 1'b0;
        chk("bp_inflight", nw, 1);
        wait_req(base + 1);
        ch_ready = '0;
        wait_idle;

        // Control traffic holds the scheduler in IDLE.
        ctrl_busy = 1'b1;
        base = n_req;
        push_n(4'b0010, 1);
        ch_ready = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            step;
            chk("ctrl_hold_idle", 32'(sched_busy), 0);
        end
        ctrl_busy = 1'b0;
        #1 chk("ctrl_fall_idle", 32'(sched_busy), 0);
        step;
        chk("ctrl_arb_entry", 32'(sched_busy), 1);
        chk("ctrl_arb_nogrant", 32'(ch_grant), 0);
        step;
        chk("ctrl_grant", 32'(ch_grant), 32'b0010);
        wait_req(base + 1);
        ch_ready = '0;
        wait_idle;

        // End pulse in the last cycle of the wait window is a normal end.
        rsp_delay = TIMEOUT;
        run_pkts(4'b0001, 1);
        chk("end_at_limit", 32'(tx_timeout), 0);
        rsp_delay = 10;

        // No end pulse: timeout flag, then the next packet still goes out.
        rsp_en = 1'b0;
        base = n_req;
        push_n(4'b0001, 1);
        ch_ready = 4'b0001;
        wait_req(base + 1);
        ch_ready = '0;
        n = 0;
        while (n < 100 && !tx_timeout) begin
            step;
            n++;
        end
        chk("timeout_cycle", n, TIMEOUT + 1);
        chk("timeout_in_gap", 32'(sched_busy), 1);
        wait_idle;
        rsp_en = 1'b1;
        run_pkts(4'b0001, 1);
        chk("timeout_sticky", 32'(tx_timeout), 1);

        // Reset after three payload bytes abandons the packet.
        base = n_req;
        exp_wr.push_back(8'd2);
        exp_wr.push_back(8'(m_seq[2]));
        for (int k = 0; k < 3; k++) exp_wr.push_back(fifo_byte(2, m_ptr[2] + k));
        ch_ready = 4'b0100;
        wait_pkt_wr(5);
        rst = 1'b1;
        ch_ready = '0;
        step;
        chk_quiet("rst_mid");
        rst = 1'b0;
        model_reset;
        repeat (3) step;
        chk("rst_mid_noreq", n_req, base);
        chk("rst_mid_wr_left", exp_wr.size(), 0);
        run_pkts(4'b0101, 1);

        chk("wr_leftover", exp_wr.size(), 0);
        chk("req_leftover", exp_req.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_tx_scheduler.md
Name: mac_tx_scheduler

Overview:
- Round-robin scheduler that shares the single UDP transmit path between NUM_CH video channel FIFOs.
- For each granted channel it:
  - writes a 2-byte tag (channel id, per-channel sequence number) into the UDP payload buffer;
  - copies PKT_LEN payload bytes from that channel's FIFO into the same buffer;
  - pulses udp_tx_req, then waits for udp_tx_end.
- Sits between the capture/splice FIFOs and the MAC TX top (udp_tx_req / ram_wr_* / udp_tx_end / almost_full).
- Defers new packets while ARP/ICMP traffic is pending.

Parameters:
- NUM_CH, 4: number of video channels (2..8).
- PKT_LEN, 1024: payload bytes read per packet (1..1470).
- GAP_CYC, 64: idle cycles inserted after each packet.
- TIMEOUT, 65535: maximum cycles to wait for udp_tx_end.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sched_en  in  1  enable for new packet starts.
- ctrl_busy  in  1  ARP/ICMP transmission pending or active; blocks starts.
- ch_ready  in  NUM_CH  bit i=1: FIFO i holds at least PKT_LEN bytes.
- ch_data  in  8*NUM_CH  FIFO read data; channel i occupies bits [8i+7:8i]; 1-cycle read latency.
- ch_rd_en  out  NUM_CH  one-hot FIFO read strobe.
- ch_grant  out  NUM_CH  one-hot; the channel owning the current packet.
- ram_wr_data  out  8  byte written to the UDP payload buffer.
- ram_wr_en  out  1  write strobe for ram_wr_data.
- almost_full  in  1  UDP buffer near full; stall reads.
- udp_tx_req  out  1  one-cycle start pulse for the UDP transmit path.
- udp_send_data_length  out  16  equals PKT_LEN+2; stable from HDR0 until GAP exits.
- udp_tx_end  in  1  one-cycle pulse: packet fully sent.
- sched_busy  out  1  high in every state except IDLE.
- tx_timeout  out  1  sticky error flag; cleared only by rst.

Behaviour:
Reset (synchronous, rst=1 sampled on clk edge):
- FSM goes to IDLE.
- Outputs: ch_rd_en, ch_grant, ram_wr_en, ram_wr_data, udp_tx_req, sched_busy and tx_timeout are all 0; udp_send_data_length=0.
- All sequence counters are 0; RR pointer last=NUM_CH-1, so channel 0 wins first.
- Reset mid-packet abandons the packet. No udp_tx_req is issued for it, and the partial FIFO data is not restored.

FSM:
- IDLE -> ARB when sched_en && !ctrl_busy && |ch_ready.
- ARB (1 cycle): search from last+1 (mod NUM_CH) upward; first channel with ch_ready set is latched into ch_grant and last. If ch_ready dropped in the meantime, return to IDLE.
- HDR0: ram_wr_en=1, ram_wr_data = channel index (zero-extended).
- HDR1: ram_wr_en=1, ram_wr_data = seq[ch].
- PAYLOAD:
  - ch_rd_en[ch]=1 whenever !almost_full and reads issued < PKT_LEN.
  - Every read issued in cycle N produces ram_wr_en=1 with ch_data byte in cycle N+1.
  - almost_full high: no new read; the one in-flight byte is still written.
  - Leave after the final read's write cycle.
- REQ: udp_tx_req=1 for exactly one cycle; seq[ch] increments (8-bit wrap 255->0).
- WAIT_END:
  - Wait for udp_tx_end.
  - Timer counts up from 0. If it reaches TIMEOUT without udp_tx_end, set tx_timeout and go to GAP.
  - udp_tx_end in the same cycle the timer reaches TIMEOUT counts as a normal end: no error.
- GAP: count GAP_CYC cycles, then clear ch_grant and go to IDLE.

Rules:
- ctrl_busy and sched_en are sampled only in IDLE; deasserting them mid-packet does not abort the packet.
- udp_tx_end outside WAIT_END is ignored.
- Only one channel is read per packet; no interleaving.
- Byte count is exactly PKT_LEN+2 per packet.

Test Plan:
- Single channel, NUM_CH=4, PKT_LEN=8:
  - Stimulus: ch_ready=4'b0001, udp_tx_end returned 10 cycles after udp_tx_req.
  - Required: 10 ram_wr_en writes, bytes 00,00,d0..d7; then one udp_tx_req with length 10. The second packet's tag is 00,01.
- Round-robin:
  - Stimulus: ch_ready=4'b1111 held.
  - Required: grant order 0,1,2,3,0. Each channel's tag sequence number increments independently.
- Back-pressure:
  - Stimulus: almost_full high for 5 cycles mid-payload.
  - Required: ch_rd_en low for those cycles, exactly one write after assertion, no byte lost or duplicated, total writes = PKT_LEN+2.
- Control priority:
  - Stimulus: ctrl_busy=1 with ch_ready=4'b0010.
  - Required: FSM stays in IDLE; ARB is entered the cycle after ctrl_busy falls.
- Timeout with TIMEOUT=20:
  - Stimulus: no udp_tx_end.
  - Required: tx_timeout=1 at cycle 20 of WAIT_END, then GAP, then the next packet proceeds. Only rst clears the flag.
- Reset mid-payload:
  - Stimulus: rst asserted after 3 payload bytes.
  - Required: next cycle all outputs are 0 and no udp_tx_req is issued. The next packet grants channel 0 with seq 0.
